// File: rtl/marvin_debounce_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : marvin_debounce_pkg
// Purpose  : Shared constants for the mechanical-input debounce front end:
//            timing defaults for the 10 MHz system clock and the board's
//            channel map (ten toggle switches plus one active-low button).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package marvin_debounce_pkg;

   // Clock cycles per millisecond at the 10 MHz system clock.
   localparam int DEBOUNCE_MS_10MHZ     = 10000;

   // 10 ms of stable input before a level change is accepted.
   localparam int DEFAULT_STABLE_CYCLES = 10 * DEBOUNCE_MS_10MHZ;

   // Board channel map.
   localparam int BOARD_CHANNELS = 11;
   localparam int SW0 = 0;
   localparam int SW1 = 1;
   localparam int SW2 = 2;
   localparam int SW3 = 3;
   localparam int SW4 = 4;
   localparam int SW5 = 5;
   localparam int SW6 = 6;
   localparam int SW7 = 7;
   localparam int SW8 = 8;
   localparam int SW9 = 9;
   localparam int BTN = 10;

   // The push-button pulls its pin low when pressed.
   localparam logic [BOARD_CHANNELS-1:0] DEFAULT_INVERT_MASK =
      BOARD_CHANNELS'(1) << BTN;

   // Counter width able to hold 0..stable_cycles.
   function automatic int cnt_width(input int stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction

endpackage : marvin_debounce_pkg
`default_nettype wire

// File: rtl/marvin_debounce_ch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : marvin_debounce_ch
// Purpose  : One debounce channel: two-flop synchroniser, stable-time
//            counter, rise/fall strobes and a sticky toggle register.
// Ports    : clk        - system clock
//            rst_       - asynchronous active-low reset
//            raw        - unsynchronised pin input
//            toggle_clr - synchronous clear of toggle (wins over rise)
//            level      - debounced, active-high level
//            rise/fall  - one-cycle strobes on level 0->1 / 1->0
//            toggle     - flips on each rise
// Revision : 1.0 - initial release
// ============================================================================
module marvin_debounce_ch
   import marvin_debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter bit INVERT        = 1'b0
) (
   input  logic clk,
   input  logic rst_,
   input  logic raw,
   input  logic toggle_clr,
   output logic level,
   output logic rise,
   output logic fall,
   output logic toggle
);

   localparam int                c_cnt_w = cnt_width(STABLE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(STABLE_CYCLES - 1);

   logic               r_s1;
   logic               r_s2;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_level;
   logic               r_rise;
   logic               r_fall;
   logic               r_toggle;
   logic               w_act;

   // Polarity-corrected synchronised input.
   assign w_act = r_s2 ^ INVERT;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         // Sync flops idle at the pin's inactive value so release is quiet.
         r_s1     <= INVERT;
         r_s2     <= INVERT;
         r_cnt    <= '0;
         r_level  <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_toggle <= 1'b0;
      end else begin
         r_s1   <= raw;
         r_s2   <= r_s1;
         r_rise <= 1'b0;
         r_fall <= 1'b0;

         // Any single cycle back at the current level restarts the count,
         // so the counter can never run past c_last.
         if (w_act == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_last) begin
            r_level <= w_act;
            r_cnt   <= '0;
            r_rise  <= w_act;
            r_fall  <= ~w_act;
         end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end

         if (toggle_clr) begin
            r_toggle <= 1'b0;
         end else if (r_rise) begin
            r_toggle <= ~r_toggle;
         end
      end
   end

   assign level  = r_level;
   assign rise   = r_rise;
   assign fall   = r_fall;
   assign toggle = r_toggle;

endmodule : marvin_debounce_ch
`default_nettype wire

// File: rtl/marvin_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : marvin_debounce
// Purpose  : N-channel debounce front end for the board's mechanical inputs.
//            Each channel is independent; the wrapper adds a single
//            any_change event covering all channel strobes.
// Ports    : clk        - system clock
//            rst_       - asynchronous active-low reset
//            raw        - [CHANNELS] unsynchronised pin inputs
//            toggle_clr - [CHANNELS] synchronous toggle clears
//            level      - [CHANNELS] debounced active-high levels
//            rise/fall  - [CHANNELS] one-cycle edge strobes
//            toggle     - [CHANNELS] sticky toggles
//            any_change - OR of all rise/fall strobes, same cycle
// Revision : 1.0 - initial release
// ============================================================================
module marvin_debounce
   import marvin_debounce_pkg::*;
#(
   parameter int                  CHANNELS      = BOARD_CHANNELS,
   parameter int                  STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter logic [CHANNELS-1:0] INVERT_MASK   = '0
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic [CHANNELS-1:0] raw,
   input  logic [CHANNELS-1:0] toggle_clr,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] toggle,
   output logic                any_change
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      marvin_debounce_ch #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .INVERT        (INVERT_MASK[i])
      ) u_ch (
         .clk        (clk),
         .rst_       (rst_),
         .raw        (raw[i]),
         .toggle_clr (toggle_clr[i]),
         .level      (level[i]),
         .rise       (rise[i]),
         .fall       (fall[i]),
         .toggle     (toggle[i])
      );
   end

   // Strobes are flop outputs, so this reduction lines up with them exactly.
   assign any_change = |(rise | fall);

endmodule : marvin_debounce
`default_nettype wire

// File: tb/tb_marvin_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_marvin_debounce
// Purpose  : Self-checking bench for marvin_debounce with 4 channels,
//            STABLE_CYCLES=4 and channel 3 active-low.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_marvin_debounce;

   localparam int              CH  = 4;
   localparam int              SC  = 4;
   localparam logic [CH-1:0]   INV = 4'b1000;

   logic          clk = 1'b0;
   logic          rst_;
   logic [CH-1:0] raw;
   logic [CH-1:0] toggle_clr;
   logic [CH-1:0] level;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic [CH-1:0] toggle;
   logic          any_change;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [CH-1:0] raw;
      logic [CH-1:0] clr;
      logic [CH-1:0] lvl;
      logic [CH-1:0] rs;
      logic [CH-1:0] fl;
      logic [CH-1:0] tg;
      logic          any;
   } vec_t;

   vec_t vecs[$];

   marvin_debounce #(
      .CHANNELS      (CH),
      .STABLE_CYCLES (SC),
      .INVERT_MASK   (INV)
   ) dut (
      .clk        (clk),
      .rst_       (rst_),
      .raw        (raw),
      .toggle_clr (toggle_clr),
      .level      (level),
      .rise       (rise),
      .fall       (fall),
      .toggle     (toggle),
      .any_change (any_change)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic add(input int n, input logic [CH-1:0] r, input logic [CH-1:0] c,
                      input logic [CH-1:0] l, input logic [CH-1:0] rs,
                      input logic [CH-1:0] fl, input logic [CH-1:0] tg, input logic a);
      vec_t v;
      v.raw = r; v.clr = c; v.lvl = l; v.rs = rs; v.fl = fl; v.tg = tg; v.any = a;
      repeat (n) vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [16:0] outs();
      return {level, rise, fall, toggle, any_change};
   endfunction

   // Press channel 2, check rise latency and resulting toggle, then release.
   task automatic press_ch2(input string tag, input logic clr_on_rise, input logic exp_tog);
      int n;
      raw[2] = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!rise[2] && n < 20);
      check({tag, "_latency"}, n, 6);
      toggle_clr[2] = clr_on_rise;
      step();
      toggle_clr[2] = 1'b0;
      check({tag, "_toggle"}, toggle[2], exp_tog);
      raw[2] = 1'b0;
      repeat (10) step();
      check({tag, "_released"}, level[2], 1'b0);
   endtask

   initial begin
      int n;

      // ---- vector table ----
      // clean press on ch0, then release
      add(5, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add(1, 4'b1001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      add(2, 4'b1001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      add(5, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      add(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b1);
      add(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      // bounce on ch1: 1,1,1,0 then held high
      add(3, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      add(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      add(5, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      add(1, 4'b1010, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 1'b1);
      add(1, 4'b1010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 1'b0);
      // active-low ch3: pin low, then back high
      add(5, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 1'b0);
      add(1, 4'b0010, 4'b0000, 4'b1010, 4'b1000, 4'b0000, 4'b0011, 1'b1);
      add(1, 4'b0010, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b1011, 1'b0);
      add(5, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b1011, 1'b0);
      add(1, 4'b1010, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b1011, 1'b1);
      add(1, 4'b1010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1011, 1'b0);

      // ---- reset and idle ----
      raw        = 4'b1000;
      toggle_clr = 4'b0000;
      rst_       = 1'b0;
      repeat (3) step();
      check("reset_state", outs(), 17'h0);
      #2 rst_ = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check($sformatf("idle_%0d", i), outs(), 17'h0);
      end

      // ---- table-driven vectors ----
      for (int i = 0; i < vecs.size(); i++) begin
         raw        = vecs[i].raw;
         toggle_clr = vecs[i].clr;
         step();
         check($sformatf("vec_%0d", i), outs(),
               {vecs[i].lvl, vecs[i].rs, vecs[i].fl, vecs[i].tg, vecs[i].any});
      end

      // ---- toggle and clear on ch2 ----
      raw = 4'b1000;
      repeat (10) step();
      press_ch2("press1", 1'b0, 1'b1);
      press_ch2("press2", 1'b0, 1'b0);
      press_ch2("press3_clr", 1'b1, 1'b0);

      // ---- reset in the middle of a count ----
      raw = 4'b1001;
      repeat (4) step();
      check("midcount_no_level", level[0], 1'b0);
      rst_ = 1'b0;
      #1;
      check("midcount_async_reset", outs(), 17'h0);
      step();
      step();
      #3 rst_ = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!rise[0] && n < 20);
      check("post_reset_latency", n, 6);
      check("post_reset_rise", rise, 4'b0001);
      check("post_reset_any", any_change, 1'b1);
      step();
      check("post_reset_single_pulse", {rise, any_change}, 5'b00000);
      check("post_reset_level", level, 4'b0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_marvin_debounce
`default_nettype wire
